// File: rtl/ahb_pkg.sv
// Shared AHB encodings used by the masters and the bus arbiter.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [1:0] {
        OKAY  = 2'd0,
        ERROR = 2'd1,
        RETRY = 2'd2,
        SPLIT = 2'd3
    } hresp_e;

endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbitration bundle between the AHB masters/slaves and the arbiter.
interface ahb_arbiter_if
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MW          = 4
) ();

    logic [NUM_MASTERS-1:0] i_hbusreq;
    logic [NUM_MASTERS-1:0] i_hlock;
    htrans_e                i_htrans;
    logic                   i_hready;
    hresp_e                 i_hresp;
    logic [NUM_MASTERS-1:0] i_hsplit;
    logic [NUM_MASTERS-1:0] o_hgrant;
    logic [MW-1:0]          o_hmaster;
    logic [MW-1:0]          o_hmaster_d;
    logic                   o_hmastlock;

    modport master (
        output i_hbusreq, i_hlock, i_htrans,
        output i_hready, i_hresp, i_hsplit,
        input  o_hgrant, o_hmaster, o_hmaster_d,
        input  o_hmastlock
    );

    modport slave (
        input  i_hbusreq, i_hlock, i_htrans,
        input  i_hready, i_hresp, i_hsplit,
        output o_hgrant, o_hmaster, o_hmaster_d,
        output o_hmastlock
    );

endinterface

// File: rtl/ahb_rr_picker.sv
// Round-robin picker: rotate by start, find lowest set bit, rotate back.
module ahb_rr_picker #(
    parameter int N  = 4,
    parameter int MW = 4
) (
    input  logic [N-1:0]  i_req,
    input  logic [MW-1:0] i_start,
    output logic          o_valid,
    output logic [MW-1:0] o_idx
);

    localparam logic [MW:0] NW = N[MW:0];

    logic [N-1:0]  rot;
    logic [MW-1:0] pos;
    logic [MW:0]   sum;

    always_comb begin
        rot = N'({i_req, i_req} >> i_start);
        pos = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) pos = MW'(i);
        end
        sum = {1'b0, pos} + {1'b0, i_start};
        if (sum >= NW) sum = sum - NW;
    end

    assign o_valid = |i_req;
    assign o_idx   = sum[MW-1:0];

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin with beat quantum, locked ownership,
// SPLIT masking and default-master parking.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int MW             = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int QUANTUM        = 4
) (
    input logic          i_hclk,
    input logic          i_hreset_n,
    ahb_arbiter_if.slave bus
);

    localparam int N = NUM_MASTERS;
    localparam logic [N-1:0]  ONE_N   = N'(1);
    localparam logic [N-1:0]  DEF_OH  = ONE_N << DEFAULT_MASTER;
    localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);
    localparam logic [MW-1:0] RR_RST  = MW'((DEFAULT_MASTER + 1) % N);
    localparam logic [MW:0]   NW      = N[MW:0];
    localparam logic [MW:0]   INC     = {{MW{1'b0}}, 1'b1};
    localparam logic [7:0]    QMAX    = 8'(QUANTUM - 1);

    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  split_q, split_d;
    logic [MW-1:0] amaster_q, amaster_d;
    logic [MW-1:0] dmaster_q, dmaster_d;
    logic [MW-1:0] rr_q, rr_d;
    logic [7:0]    beat_q, beat_d;
    logic          mastlock_q, mastlock_d;
    logic          rsseen_q, rsseen_d;

    logic          pick_vld;
    logic [MW-1:0] pick_idx;
    logic [MW-1:0] gidx;
    logic [MW-1:0] win_idx;
    logic [N-1:0]  win_oh;
    logic [MW:0]   nxt;
    logic          beat, own_lock, own_req, rearb;
    logic          split_first;

    ahb_rr_picker #(.N(N), .MW(MW)) u_pick (
        .i_req   (bus.i_hbusreq & ~split_q),
        .i_start (rr_q),
        .o_valid (pick_vld),
        .o_idx   (pick_idx)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) gidx = MW'(i);
        end
    end

    always_comb begin
        beat = bus.i_htrans == NONSEQ || bus.i_htrans == SEQ;
        own_lock = |(bus.i_hlock & grant_q);
        own_req = |(bus.i_hbusreq & grant_q);
        split_first = !bus.i_hready && bus.i_hresp == SPLIT;
        rsseen_d = !bus.i_hready &&
                   (bus.i_hresp == SPLIT || bus.i_hresp == RETRY);

        rearb = bus.i_hready && (
                (!own_lock && bus.i_htrans == IDLE) ||
                !own_req ||
                (!own_lock && beat && beat_q == QMAX) ||
                grant_q == '0 ||
                rsseen_q);

        // A split-masked default master means nobody parks on the bus.
        win_idx = pick_vld ? pick_idx : DEF_IDX;
        if (pick_vld) win_oh = ONE_N << pick_idx;
        else if ((split_q & DEF_OH) != '0) win_oh = '0;
        else win_oh = DEF_OH;

        nxt = {1'b0, win_idx} + INC;
        if (nxt >= NW) nxt = '0;

        grant_d = grant_q;
        rr_d = rr_q;
        if (rearb) begin
            grant_d = win_oh;
            if (win_oh != '0 && win_oh != grant_q)
                rr_d = nxt[MW-1:0];
        end
        if (split_first) grant_d = grant_d & ~(ONE_N << dmaster_q);

        split_d = split_q & ~bus.i_hsplit;
        if (split_first) split_d = split_d | (ONE_N << dmaster_q);

        beat_d = beat_q;
        amaster_d = amaster_q;
        dmaster_d = dmaster_q;
        mastlock_d = mastlock_q;
        if (bus.i_hready) begin
            if (rearb) beat_d = '0;
            else if (beat && beat_q != QMAX) beat_d = beat_q + 8'd1;
            if (grant_q != '0) amaster_d = gidx;
            dmaster_d = amaster_q;
            mastlock_d = own_lock;
        end
    end

    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            grant_q    <= DEF_OH;
            split_q    <= '0;
            amaster_q  <= DEF_IDX;
            dmaster_q  <= DEF_IDX;
            rr_q       <= RR_RST;
            beat_q     <= '0;
            mastlock_q <= 1'b0;
            rsseen_q   <= 1'b0;
        end else begin
            grant_q    <= grant_d;
            split_q    <= split_d;
            amaster_q  <= amaster_d;
            dmaster_q  <= dmaster_d;
            rr_q       <= rr_d;
            beat_q     <= beat_d;
            mastlock_q <= mastlock_d;
            rsseen_q   <= rsseen_d;
        end
    end

    assign bus.o_hgrant    = grant_q;
    assign bus.o_hmaster   = amaster_q;
    assign bus.o_hmaster_d = dmaster_q;
    assign bus.o_hmastlock = mastlock_q;

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Multi-master AHB bus arbiter that shares one AHB slave segment between up to `NUM_MASTERS` `ahb_master` instances. It collects `hbusreq`/`hlock` from every master and produces a one-hot registered `hgrant`. It drives the `hmaster` address-phase and data-phase mux selects and `hmastlock`. It implements round-robin fairness with a beat quantum, locked-transfer ownership, SPLIT masking, and default-master parking.

## Interface
Parameters:
- `NUM_MASTERS`, default 4: number of requesters, 2..16.
- `MW`, default 4: width of master index; must be at least clog2(`NUM_MASTERS`).
- `DEFAULT_MASTER`, default 0: park master when no eligible request.
- `QUANTUM`, default 4: completed beats an owner may issue before forced rearbitration, 1..255.

Ports:
- `i_hclk` in 1: clock.
- `i_hreset_n` in 1: reset, asynchronous, active-low. Clock is `i_hclk`.
- `i_hbusreq` in NUM_MASTERS: per-master bus request.
- `i_hlock` in NUM_MASTERS: per-master lock request.
- `i_htrans` in 2: muxed HTRANS of current address-phase owner.
- `i_hready` in 1: muxed HREADY.
- `i_hresp` in 2: muxed HRESP.
- `i_hsplit` in NUM_MASTERS: OR of all slave HSPLITx; a set bit releases that master.
- `o_hgrant` out NUM_MASTERS: one-hot grant, or all-zero.
- `o_hmaster` out MW: address-phase owner index (address/control mux select).
- `o_hmaster_d` out MW: data-phase owner index (HWDATA mux, HRESP routing).
- `o_hmastlock` out 1: current address-phase transfer is locked.

## Operation
Eligible set: `i_hbusreq & ~split_mask`.

Winner selection (combinational):
- Round-robin search starting at `rr_ptr`.
- If no master is eligible, the winner is `DEFAULT_MASTER`.
- If no master is eligible and `split_mask[DEFAULT_MASTER]` is set, there is no winner: all-zero grant.

Rearbitration occurs at a rising edge with `i_hready`=1 when any of the following holds:
- the owner is not locked (`i_hlock[owner]`=0) and `i_htrans`==IDLE;
- the owner's `i_hbusreq` is 0;
- `beat_cnt`==`QUANTUM-1` and a beat completes;
- `o_hgrant` is all-zero;
- a SPLIT or RETRY first cycle was seen in the preceding cycle.

A locked owner (`i_hlock[owner]`=1) is never preempted by the quantum, but is still preempted by SPLIT masking.

On rearbitration:
- `o_hgrant` <= one-hot(winner).
- If the winner differs from the owner, `rr_ptr` <= winner+1 mod `NUM_MASTERS`.
- `beat_cnt` <= 0.

`beat_cnt` increments on each edge with `i_hready` and `i_htrans` ∈ {NONSEQ, SEQ}. It saturates at `QUANTUM-1`.

Ownership tracking, on each edge with `i_hready`=1:
- `o_hmaster` <= index of the currently asserted `o_hgrant` bit, held if the grant is all-zero.
- `o_hmaster_d` <= `o_hmaster`.
- `o_hmastlock` <= `i_hlock[index of o_hgrant]`.

SPLIT handling:
- On the first SPLIT cycle (`i_hresp`==SPLIT, `i_hready`=0): `split_mask[o_hmaster_d]` <= 1, and `o_hgrant[o_hmaster_d]` drops at the same edge.
- `split_mask[k]` clears on any edge where `i_hsplit[k]`=1.
- If set and clear hit the same bit in the same cycle, set wins.

RETRY handling: the master keeps eligibility, and fairness is via `rr_ptr`.

ERROR responses need no special action.

## Timing
Reset values:
- `o_hgrant` = one-hot(`DEFAULT_MASTER`)
- `o_hmaster` = `DEFAULT_MASTER`
- `o_hmaster_d` = `DEFAULT_MASTER`
- `o_hmastlock` = 0
- `split_mask` = 0
- `rr_ptr` = `DEFAULT_MASTER`+1 mod N
- `beat_cnt` = 0

Latency and timing rules:
- All outputs are registered. Request to `o_hgrant` takes a minimum of 1 cycle when the bus is rearbitrable with `i_hready`=1.
- `o_hmaster` lags `o_hgrant` by one `i_hready` edge; `o_hmaster_d` lags `o_hmaster` by one `i_hready` edge.
- With `i_hready`=0, `o_hgrant`, `o_hmaster`, `o_hmaster_d`, `o_hmastlock` and `beat_cnt` hold. The only exception is the SPLIT-mask grant drop.
- Reset mid-transfer returns all state to the reset values immediately (asynchronous reset).

## Structure
- Shared package `ahb_pkg`: HTRANS constants IDLE/BUSY/NONSEQ/SEQ = 0/1/2/3 and HRESP constants OKAY/ERROR/RETRY/SPLIT = 0/1/2/3, used by `ahb_master` and the arbiter.
- One combinational sub-module, `ahb_rr_picker`: (req vector, start pointer) -> (valid, index), a rotate-priority-encode-unrotate picker.

## Test plan
- **Reset and parking:** reset with no requests -> `o_hgrant`=4'b0001, `o_hmaster`=0; after 10 cycles, unchanged.
- **Round-robin:** masters 1 and 2 request continuously, `i_htrans`=SEQ, `i_hready`=1 -> grant alternates every 4 beats: 1,2,1,2.
- **Lock:** master 3 holds `i_hlock`=1 for 10 beats while master 1 requests -> grant stays at 3 for the 10 beats and moves to 1 within 1 cycle of lock drop.
- **SPLIT:** master 2 owns the data phase and `i_hresp`=SPLIT for 2 cycles -> `o_hgrant[2]`=0 and master 2 is not granted despite `hbusreq`; assert `i_hsplit[2]` -> master 2 is granted at its next round-robin turn.
- **Wait states:** `i_hready`=0 for 3 cycles during a handover -> `o_hmaster` and `o_hmaster_d` hold, then advance on consecutive `i_hready` edges.
- **Split default:** `DEFAULT_MASTER` split-masked with no requests -> `o_hgrant`=0; `i_hsplit[0]` -> grant returns to 4'b0001 next cycle.
